// File: rtl/interleaver_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : interleaver_ctrl
// Description : Frame sequencer for the block interleaver core. It splits a
//               frame into OFDM symbols, fills each symbol, then drains it.
// Revision    : 1.0 - initial release
// ============================================================================
module interleaver_ctrl #(
  parameter int NCBPS = 48,
  parameter int AW    = 7
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [11:0]   size,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          il_sym_start,
  output logic          il_wr_en,
  output logic [AW-1:0] il_wr_addr,
  output logic          il_pad,
  output logic [AW-1:0] il_rd_addr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last,
  output logic [10:0]   sym_cnt,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SYM   = 3'd1,
    FILL  = 3'd2,
    DRAIN = 3'd3,
    FIN   = 3'd4
  } state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(NCBPS - 1);

  state_t        state, state_nxt;
  logic [15:0]   remaining;
  logic [AW-1:0] wr_cnt, rd_cnt;
  logic [10:0]   sym_cnt_q;
  logic          rem_zero;

  assign rem_zero   = (remaining == 16'd0);
  assign il_wr_addr = wr_cnt;
  assign il_rd_addr = rd_cnt;
  assign sym_cnt    = sym_cnt_q;

  always_comb begin
    state_nxt    = state;
    in_ready     = 1'b0;
    il_sym_start = 1'b0;
    il_wr_en     = 1'b0;
    il_pad       = 1'b0;
    out_valid    = 1'b0;
    out_last     = 1'b0;
    done         = 1'b0;
    busy         = (state != IDLE);
    case (state)
      IDLE: begin
        if (start) state_nxt = (size != 12'd0) ? SYM : FIN;
      end
      SYM: begin
        il_sym_start = 1'b1;
        state_nxt    = FILL;
      end
      FILL: begin
        // Once the frame's coded bits run out, pad one zero per cycle.
        in_ready = !rem_zero;
        il_pad   = rem_zero;
        il_wr_en = rem_zero | in_valid;
        if (il_wr_en && (wr_cnt == LAST_IDX)) state_nxt = DRAIN;
      end
      DRAIN: begin
        out_valid = 1'b1;
        out_last  = (rd_cnt == LAST_IDX) && rem_zero;
        if (out_ready && (rd_cnt == LAST_IDX)) state_nxt = rem_zero ? FIN : SYM;
      end
      FIN: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      remaining <= 16'd0;
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      sym_cnt_q <= 11'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            remaining <= {size, 4'b0000};
            if (size != 12'd0) sym_cnt_q <= 11'd0;
          end
        end
        SYM: begin
          sym_cnt_q <= sym_cnt_q + 11'd1;
          wr_cnt    <= '0;
        end
        FILL: begin
          if (il_wr_en) begin
            wr_cnt <= wr_cnt + 1'b1;
            if (!rem_zero) remaining <= remaining - 16'd1;
            if (wr_cnt == LAST_IDX) rd_cnt <= '0;
          end
        end
        DRAIN: begin
          if (out_ready) rd_cnt <= rd_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_interleaver_ctrl.sv
`default_nettype none
// Bench for interleaver_ctrl: expected core/mapper events are queued at frame
// start and checked by an independent monitor as the DUT produces them.
module tb_interleaver_ctrl;

  localparam int NCBPS = 48;
  localparam int AW    = 7;
  localparam int K_SYM = 0, K_WR = 1, K_RD = 2, K_DONE = 3;
  localparam int NOCNT = -1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [11:0]   size = 12'd0;
  logic          in_valid = 1'b1;
  logic          in_ready;
  logic          il_sym_start, il_wr_en, il_pad, out_valid, out_last, busy, done;
  logic [AW-1:0] il_wr_addr, il_rd_addr;
  logic          out_ready = 1'b1;
  logic [10:0]   sym_cnt;

  typedef struct {int kind; int addr; int flag; int cnt;} ev_t;
  ev_t exp_q[$];

  int total = 0, bad = 0;
  int acc_cnt = 0, pad_cnt = 0, xfer_cnt = 0;
  int cyc = 0, last_rd_cyc = -100;
  bit tog_mode = 1'b0;

  interleaver_ctrl #(.NCBPS(NCBPS), .AW(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .size(size),
    .in_valid(in_valid), .in_ready(in_ready), .il_sym_start(il_sym_start),
    .il_wr_en(il_wr_en), .il_wr_addr(il_wr_addr), .il_pad(il_pad),
    .il_rd_addr(il_rd_addr), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .sym_cnt(sym_cnt), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  function automatic void push(input int k, input int a, input int f, input int c);
    ev_t e;
    e.kind = k; e.addr = a; e.flag = f; e.cnt = c;
    exp_q.push_back(e);
  endfunction

  // Expected event stream of one frame: symbol starts, writes, reads, done.
  function automatic void push_frame(input int sz);
    int rem, nsym;
    rem  = sz * 16;
    nsym = (rem + NCBPS - 1) / NCBPS;
    for (int s = 0; s < nsym; s++) begin
      push(K_SYM, 0, 0, NOCNT);
      for (int k = 0; k < NCBPS; k++) begin
        push(K_WR, k, (rem == 0) ? 1 : 0, NOCNT);
        if (rem != 0) rem--;
      end
      for (int k = 0; k < NCBPS; k++)
        push(K_RD, k, (k == NCBPS - 1 && rem == 0) ? 1 : 0, NOCNT);
    end
    push(K_DONE, 0, 0, (sz == 0) ? NOCNT : nsym);
  endfunction

  task automatic check_ev(input int k, input int a, input int f, input int c);
    ev_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL unexpected_event: got kind=%0d addr=%0d, expected none", k, a);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.addr != a || e.flag != f || (e.cnt != NOCNT && e.cnt != c)) begin
        bad++;
        $display("FAIL event: got kind=%0d addr=%0d flag=%0d cnt=%0d expected kind=%0d addr=%0d flag=%0d cnt=%0d",
                 k, a, f, c, e.kind, e.addr, e.flag, e.cnt);
      end
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (!reset) begin
      if (il_sym_start) check_ev(K_SYM, 0, 0, 0);
      if (il_wr_en) begin
        check_ev(K_WR, int'(il_wr_addr), int'(il_pad), 0);
        check("in_ready_vs_pad", int'(in_ready), int'(!il_pad));
        if (il_pad) pad_cnt++;
      end
      if (in_valid && in_ready) acc_cnt++;
      if (out_valid && out_ready) begin
        check_ev(K_RD, int'(il_rd_addr), int'(out_last), 0);
        xfer_cnt++;
        last_rd_cyc = cyc;
      end
      if (done) begin
        check_ev(K_DONE, 0, 0, int'(sym_cnt));
        if (last_rd_cyc >= 0) check("done_after_last", cyc - last_rd_cyc, 1);
        last_rd_cyc = -100;
      end
      if (il_wr_en || out_valid)
        check("wr_rd_exclusive", int'(il_wr_en && out_valid), 0);
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1 out_ready = tog_mode ? ~out_ready : 1'b1;
    end
  end

  task automatic start_frame(input int sz);
    @(posedge clk);
    #1;
    acc_cnt = 0; pad_cnt = 0; xfer_cnt = 0;
    push_frame(sz);
    start = 1'b1;
    size  = 12'(sz);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      total++; bad++;
      $display("FAIL %s_timeout: got no done, expected done", name);
    end
    @(negedge clk);
    check({name, "_idle"}, int'(busy), 0);
    check({name, "_queue_empty"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    // Reset values
    #2;
    check("rst_busy", int'(busy), 0);
    check("rst_outputs", int'({in_ready, il_sym_start, il_wr_en, il_pad, out_valid, out_last, done}), 0);
    check("rst_sym_cnt", int'(sym_cnt), 0);
    check("rst_wr_addr", int'(il_wr_addr), 0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Size=3 streaming: latency and single symbol
    @(posedge clk);
    #1;
    acc_cnt = 0; pad_cnt = 0; xfer_cnt = 0;
    push_frame(3);
    start = 1'b1; size = 12'd3;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("f1_sym_start", int'(il_sym_start), 1);
    @(negedge clk);
    check("f1_first_write", int'(il_wr_en), 1);
    wait_done("f1");
    check("f1_sym_cnt", int'(sym_cnt), 1);
    check("f1_pads", pad_cnt, 0);
    check("f1_accepted", acc_cnt, 48);
    check("f1_transfers", xfer_cnt, 48);

    // Size=4: two symbols, 32 pad bits in the second
    start_frame(4);
    wait_done("f2");
    check("f2_sym_cnt", int'(sym_cnt), 2);
    check("f2_accepted", acc_cnt, 64);
    check("f2_pads", pad_cnt, 32);

    // Size=3 with Out_Ready toggling during drain
    tog_mode = 1'b1;
    start_frame(3);
    begin
      int xf = 0;
      bit got = 1'b0;
      for (int i = 0; i < 300 && !got; i++) begin
        @(negedge clk);
        if (out_valid) got = 1'b1;
      end
      check("f3_drain_reached", int'(got), 1);
      for (int i = 0; i < 200 && xf < 48; i++) begin
        check("f3_out_valid_held", int'(out_valid), 1);
        if (out_ready) xf++;
        if (xf < 48) @(negedge clk);
      end
      check("f3_transfers", xf, 48);
    end
    wait_done("f3");
    tog_mode = 1'b0;
    check("f3_monitor_transfers", xfer_cnt, 48);

    // Size=3 with a 10-cycle In_Valid gap after write 10
    start_frame(3);
    begin
      bit got = 1'b0;
      for (int i = 0; i < 100 && !got; i++) begin
        @(negedge clk);
        if (il_wr_en && il_wr_addr == 7'd10) got = 1'b1;
      end
      check("f4_reached_w10", int'(got), 1);
      @(posedge clk);
      #1 in_valid = 1'b0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        check("f4_gap_no_write", int'(il_wr_en), 0);
        check("f4_gap_addr_hold", int'(il_wr_addr), 11);
      end
      @(posedge clk);
      #1 in_valid = 1'b1;
    end
    wait_done("f4");
    check("f4_accepted", acc_cnt, 48);

    // Start during DRAIN is ignored
    start_frame(3);
    begin
      bit got = 1'b0;
      for (int i = 0; i < 100 && !got; i++) begin
        @(negedge clk);
        if (out_valid) got = 1'b1;
      end
      check("f5_drain_reached", int'(got), 1);
      @(posedge clk);
      #1 start = 1'b1; size = 12'd5;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      check("f5_sym_cnt_kept", int'(sym_cnt), 1);
    end
    wait_done("f5");
    check("f5_sym_cnt_end", int'(sym_cnt), 1);

    // Size=0: Done one cycle after Start, no symbol
    start_frame(0);
    @(negedge clk);
    check("f6_done", int'(done), 1);
    check("f6_no_sym_start", int'(il_sym_start), 0);
    @(negedge clk);
    check("f6_idle", int'(busy), 0);
    check("f6_queue_empty", exp_q.size(), 0);
    exp_q.delete();

    // Reset at write 20 of symbol 1 (Size=10), then a Size=1 frame
    start_frame(10);
    begin
      bit got = 1'b0;
      for (int i = 0; i < 100 && !got; i++) begin
        @(negedge clk);
        if (il_wr_en && il_wr_addr == 7'd20) got = 1'b1;
      end
      check("f7_reached_w20", int'(got), 1);
      #1 reset = 1'b1;
      #1;
      check("f7_async_wr_en", int'(il_wr_en), 0);
      check("f7_async_busy", int'(busy), 0);
      check("f7_async_in_ready", int'(in_ready), 0);
      check("f7_async_sym_cnt", int'(sym_cnt), 0);
      check("f7_async_wr_addr", int'(il_wr_addr), 0);
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      repeat (5) @(negedge clk);
      check("f7_no_done_after_abort", int'(done || busy), 0);
    end
    start_frame(1);
    wait_done("f8");
    check("f8_pads", pad_cnt, 32);
    check("f8_accepted", acc_cnt, 16);
    check("f8_sym_cnt", int'(sym_cnt), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got stuck, expected finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
